// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin arbiter: state encoding and defaults.
package arb_pkg;

  // Arbiter control states.
  typedef enum logic {
    StIdle = 1'b0,
    StBusy = 1'b1
  } state_t;

  localparam int unsigned DefaultW       = 32;
  localparam int unsigned DefaultMaxHold = 16;
  // Width of a requester index for the default requester count.
  localparam int unsigned DefaultIdxW    = $clog2(DefaultW);

endpackage

// File: rtl/rr_arb_32_pe_lsb.sv
// Combinational lowest-set-bit priority encoder. idx is 0 when nothing is set.
module pe_lsb #(
  parameter int unsigned W  = 32,
  parameter int unsigned IW = $clog2(W)
) (
  input  logic [W-1:0]  vec,
  output logic [IW-1:0] idx,
  output logic          found
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx   = '0;
    found = |vec;
    for (int i = int'(W) - 1; i >= 0; i--) begin
      if (vec[i]) idx = IW'(i);
    end
  end

endmodule

// File: rtl/rr_arb_32.sv
// Round-robin arbiter: single registered one-hot owner, rotating priority,
// release on done / request drop / hold limit, zero-bubble re-grant.
module rr_arb_32
  import arb_pkg::*;
#(
  parameter int unsigned W        = DefaultW,
  parameter int unsigned MAX_HOLD = DefaultMaxHold,
  localparam int unsigned IW      = $clog2(W),
  localparam int unsigned CW      = $clog2(MAX_HOLD + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  req,
  input  logic          done,
  output logic [W-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_val,
  output logic          timeout
);

  state_t        state;
  logic [IW-1:0] ptr;
  logic [CW-1:0] cnt;

  logic          hold_lim;
  logic          own_req;
  logic          rel;
  logic [IW-1:0] nxt_ptr;
  logic [IW-1:0] sptr;
  logic [W-1:0]  masked;
  logic [IW-1:0] m_idx;
  logic [IW-1:0] r_idx;
  logic          m_found;
  logic          r_found;
  logic [IW-1:0] pick_idx;
  logic          pick_found;

  // Release decision and the search start point; on release the search
  // starts just past the current owner so it is considered last.
  always_comb begin
    hold_lim = (cnt == CW'(MAX_HOLD - 1));
    own_req  = req[gnt_idx];
    rel      = (state == StBusy) && (done || !own_req || hold_lim);
    nxt_ptr  = gnt_idx + IW'(1);
    sptr     = (state == StBusy) ? nxt_ptr : ptr;
    for (int i = 0; i < int'(W); i++) begin
      masked[i] = req[i] && (IW'(i) >= sptr);
    end
  end

  pe_lsb #(
    .W  (W),
    .IW (IW)
  ) u_pe_masked (
    .vec   (masked),
    .idx   (m_idx),
    .found (m_found)
  );

  pe_lsb #(
    .W  (W),
    .IW (IW)
  ) u_pe_raw (
    .vec   (req),
    .idx   (r_idx),
    .found (r_found)
  );

  // Wrap to the raw vector when nothing at or above the pointer requests.
  always_comb begin
    pick_idx   = m_found ? m_idx : r_idx;
    pick_found = r_found;
  end

  // Arbiter FSM with registered grant outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= StIdle;
      ptr     <= '0;
      cnt     <= '0;
      gnt     <= '0;
      gnt_idx <= '0;
      gnt_val <= 1'b0;
      timeout <= 1'b0;
    end else begin
      timeout <= 1'b0;
      unique case (state)
        StIdle: begin
          if (pick_found) begin
            gnt     <= W'(1) << pick_idx;
            gnt_idx <= pick_idx;
            gnt_val <= 1'b1;
            cnt     <= '0;
            state   <= StBusy;
          end
        end
        StBusy: begin
          if (rel) begin
            ptr     <= nxt_ptr;
            // Forced revocation only; a coincident done or drop is a normal release.
            timeout <= hold_lim && !done && own_req;
            if (pick_found) begin
              gnt     <= W'(1) << pick_idx;
              gnt_idx <= pick_idx;
              cnt     <= '0;
            end else begin
              gnt     <= '0;
              gnt_val <= 1'b0;
              state   <= StIdle;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arb_32.sv
// Scoreboard bench for rr_arb_32: driver queues hand-computed expectations,
// monitor pops and compares one entry after each rising edge.
module tb_rr_arb_32;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] req;
  logic        done;
  logic [31:0] gnt;
  logic [4:0]  gnt_idx;
  logic        gnt_val;
  logic        timeout;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       val;
    logic [4:0] idx;
    logic       to;
    string      name;
  } exp_t;

  exp_t exp_q[$];

  rr_arb_32 #(
    .W        (32),
    .MAX_HOLD (16)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_val (gnt_val),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive one cycle of stimulus and queue what should be visible after the next edge.
  task automatic step(input logic [31:0] r, input logic d, input logic ev, input int ei,
                      input logic et, input string nm);
    exp_t e;
    @(negedge clk);
    req    = r;
    done   = d;
    e.val  = ev;
    e.idx  = 5'(ei);
    e.to   = et;
    e.name = nm;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    req = '0;
    done = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: compare every field of the registered outputs.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({e.name, ".gnt_val"}, {31'b0, gnt_val}, {31'b0, e.val});
        check({e.name, ".gnt_idx"}, {27'b0, gnt_idx}, {27'b0, e.idx});
        check({e.name, ".gnt"}, gnt, e.val ? (32'h1 << e.idx) : 32'h0);
        check({e.name, ".timeout"}, {31'b0, timeout}, {31'b0, e.to});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    rst  = 1'b1;
    req  = '0;
    done = 1'b0;
    #12;
    check("rst.gnt", gnt, 32'h0);
    check("rst.gnt_idx", {27'b0, gnt_idx}, 32'h0);
    check("rst.gnt_val", {31'b0, gnt_val}, 32'h0);
    check("rst.timeout", {31'b0, timeout}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Reset and single request; done after req drop leaves arbiter idle.
    step(32'h0, 1'b1, 1'b0, 0, 1'b0, "idle_done_ignored");
    step(32'h1, 1'b0, 1'b1, 0, 1'b0, "single_grant");
    step(32'h0, 1'b1, 1'b0, 0, 1'b0, "single_release");

    // Round-robin order from ptr=0 with done every granted cycle.
    do_reset();
    step(32'h8000_0101, 1'b0, 1'b1, 0,  1'b0, "rr0");
    step(32'h8000_0101, 1'b1, 1'b1, 8,  1'b0, "rr8");
    step(32'h8000_0101, 1'b1, 1'b1, 31, 1'b0, "rr31");
    step(32'h8000_0101, 1'b1, 1'b1, 0,  1'b0, "rr_wrap0");
    step(32'h8000_0101, 1'b1, 1'b1, 8,  1'b0, "rr8b");
    step(32'h0,         1'b1, 1'b0, 8,  1'b0, "rr_idle");

    // Sole requester times out and is immediately re-granted.
    step(32'h10, 1'b0, 1'b1, 4, 1'b0, "to_grant");
    for (int i = 0; i < 15; i++) step(32'h10, 1'b0, 1'b1, 4, 1'b0, "to_hold");
    step(32'h10, 1'b0, 1'b1, 4, 1'b1, "to_pulse");
    step(32'h10, 1'b0, 1'b1, 4, 1'b0, "to_after");
    step(32'h0,  1'b0, 1'b0, 4, 1'b0, "to_drop");

    // Timeout alternates between two continuous requesters (ptr=5 here).
    step(32'h11, 1'b0, 1'b1, 0, 1'b0, "comp_g0");
    for (int i = 0; i < 15; i++) step(32'h11, 1'b0, 1'b1, 0, 1'b0, "comp_h0");
    step(32'h11, 1'b0, 1'b1, 4, 1'b1, "comp_to4");
    for (int i = 0; i < 15; i++) step(32'h11, 1'b0, 1'b1, 4, 1'b0, "comp_h4");
    step(32'h11, 1'b0, 1'b1, 0, 1'b1, "comp_to0");
    step(32'h0,  1'b0, 1'b0, 0, 1'b0, "comp_drop");

    // done coinciding with the hold limit is a normal release (ptr=1 here).
    step(32'h11, 1'b0, 1'b1, 4, 1'b0, "coin_g4");
    for (int i = 0; i < 15; i++) step(32'h11, 1'b0, 1'b1, 4, 1'b0, "coin_h4");
    step(32'h11, 1'b1, 1'b1, 0, 1'b0, "coin_rel");
    step(32'h0,  1'b0, 1'b0, 0, 1'b0, "coin_drop");

    // Owner 5 withdraws; next owner is 9 with no bubble (ptr=1 here).
    step(32'h220, 1'b0, 1'b1, 5, 1'b0, "wd_g5");
    step(32'h200, 1'b0, 1'b1, 9, 1'b0, "wd_g9");

    // Asynchronous reset mid-grant clears outputs before the next edge.
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async.gnt", gnt, 32'h0);
    check("async.gnt_idx", {27'b0, gnt_idx}, 32'h0);
    check("async.gnt_val", {31'b0, gnt_val}, 32'h0);
    check("async.timeout", {31'b0, timeout}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    req = '0;
    step(32'h0,         1'b0, 1'b0, 0, 1'b0, "post_rst_idle");
    step(32'h8000_0000, 1'b0, 1'b1, 31, 1'b0, "post_rst_g31");
    step(32'h0,         1'b0, 1'b0, 31, 1'b0, "post_rst_drop");

    repeat (4) @(posedge clk);
    #2;
    check("scoreboard_drained", exp_q.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
